nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl_if.sv | 43 ++++
 rtl/nibble_serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake and external-adder bundle for nibble_serial_add_ctrl.
// The op_sub field is present only when SERIAL_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_cin;
`ifdef SERIAL_SUB_EN
    logic          op_sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          result_cout;
    logic [3:0]    adder_a;
    logic [3:0]    adder_b;
    logic          adder_cin;
    logic [3:0]    adder_sum;
    logic          adder_cout;

    // slave: the sequencer itself
    modport slave (
`ifdef SERIAL_SUB_EN
        input  op_sub,
`endif
        input  in_valid, op_a, op_b, op_cin, out_ready, adder_sum, adder_cout,
        output in_ready, out_valid, result, result_cout, adder_a, adder_b, adder_cin
    );

    // master: operand producer, result consumer and the attached adder
    modport master (
`ifdef SERIAL_SUB_EN
        output op_sub,
`endif
        output in_valid, op_a, op_b, op_cin, out_ready, adder_sum, adder_cout,
        input  in_ready, out_valid, result, result_cout, adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit adder: streams one nibble per cycle (LSB first) through an external
// 4-bit combinational adder. Define SERIAL_SUB_EN to add op_sub (A - B) support.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_add_ctrl_if.slave s_if
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_a_sh;
    logic [W-1:0]   r_b_sh;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_result;
    logic           r_result_cout;
    logic           r_in_ready;
    logic           r_out_valid;

    logic           w_run;
    logic [W-1:0]   w_res_next;
    logic [W-1:0]   w_b_load;
    logic           w_cin_load;

    assign w_run = (r_state == RUN);

    // Adder inputs are forced to zero whenever no nibble is in flight
    assign s_if.adder_a   = w_run ? r_a_sh[3:0] : 4'd0;
    assign s_if.adder_b   = w_run ? r_b_sh[3:0] : 4'd0;
    assign s_if.adder_cin = w_run ? r_carry     : 1'b0;

    assign s_if.in_ready    = r_in_ready;
    assign s_if.out_valid   = r_out_valid;
    assign s_if.result      = r_result;
    assign s_if.result_cout = r_result_cout;

`ifdef SERIAL_SUB_EN
    // Subtraction as A + ~B + 1; carry out then means "no borrow"
    assign w_b_load   = s_if.op_sub ? ~s_if.op_b : s_if.op_b;
    assign w_cin_load = s_if.op_sub ? 1'b1 : s_if.op_cin;
`else
    assign w_b_load   = s_if.op_b;
    assign w_cin_load = s_if.op_cin;
`endif

    // Partial-sum shift register holds the nibbles already produced; the newest
    // nibble enters at the top so the final word lands in place after NIBBLES steps.
    generate
        if (NIBBLES == 1) begin : g_one
            assign w_res_next = s_if.adder_sum;
        end else begin : g_many
            logic [W-5:0] r_res_sh;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_res_sh <= '0;
                end else if (w_run) begin
                    r_res_sh <= w_res_next[W-1:4];
                end
            end

            assign w_res_next = {s_if.adder_sum, r_res_sh};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_a_sh        <= '0;
            r_b_sh        <= '0;
            r_carry       <= 1'b0;
            r_cnt         <= '0;
            r_result      <= '0;
            r_result_cout <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_if.in_valid && r_in_ready) begin
                        r_a_sh     <= s_if.op_a;
                        r_b_sh     <= w_b_load;
                        r_carry    <= w_cin_load;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh  <= r_a_sh >> 4;
                    r_b_sh  <= r_b_sh >> 4;
                    r_carry <= s_if.adder_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_result      <= w_res_next;
                        r_result_cout <= s_if.adder_cout;
                        r_out_valid   <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    if (s_if.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: 4-nibble and 1-nibble instances, each with a
// behavioural 4-bit adder attached; results checked against plain W-bit arithmetic.
module tb_nibble_serial_add_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.NIBBLES(4)) bus4 ();
    nibble_serial_add_ctrl_if #(.NIBBLES(1)) bus1 ();

    assign {bus4.adder_cout, bus4.adder_sum} =
        {1'b0, bus4.adder_a} + {1'b0, bus4.adder_b} + {4'd0, bus4.adder_cin};
    assign {bus1.adder_cout, bus1.adder_sum} =
        {1'b0, bus1.adder_a} + {1'b0, bus1.adder_b} + {4'd0, bus1.adder_cin};

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .s_if(bus4));
    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .s_if(bus1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the 4-nibble instance, holding off out_ready for 'hold' cycles
    task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input int hold);
        logic [16:0] full;
        logic [16:0] mask;
        logic [16:0] part;
        logic [15:0] exp_res;
        logic        exp_cout;
        if (sub) begin
            exp_res  = a - b;
            exp_cout = (a >= b);
        end else begin
            full     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            exp_res  = full[15:0];
            exp_cout = full[16];
        end
        check("idle_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        check("idle_adder_a", {28'd0, bus4.adder_a}, 32'd0);
        bus4.in_valid = 1'b1;
        bus4.op_a     = a;
        bus4.op_b     = b;
        bus4.op_cin   = cin;
`ifdef SERIAL_SUB_EN
        bus4.op_sub   = sub;
`endif
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus4.in_valid = 1'($urandom);
            bus4.op_a     = 16'($urandom);
            bus4.op_b     = 16'($urandom);
            bus4.op_cin   = 1'($urandom);
            check("run_out_valid", {31'd0, bus4.out_valid}, 32'd0);
            check("run_in_ready", {31'd0, bus4.in_ready}, 32'd0);
            if (!sub) begin
                mask = (17'd1 << (4 * k)) - 17'd1;
                part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, cin};
                check("adder_a", {28'd0, bus4.adder_a}, 32'((a >> (4 * k)) & 16'hF));
                check("adder_b", {28'd0, bus4.adder_b}, 32'((b >> (4 * k)) & 16'hF));
                check("adder_cin", {31'd0, bus4.adder_cin}, {31'd0, part[4 * k]});
            end
            @(negedge clk);
        end
        check("done_out_valid", {31'd0, bus4.out_valid}, 32'd1);
        check("result", {16'd0, bus4.result}, {16'd0, exp_res});
        check("result_cout", {31'd0, bus4.result_cout}, {31'd0, exp_cout});
        for (int h = 0; h < hold; h++) begin
            bus4.in_valid = ~bus4.in_valid;
            bus4.op_a     = 16'($urandom);
            @(negedge clk);
            check("hold_out_valid", {31'd0, bus4.out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, bus4.in_ready}, 32'd0);
            check("hold_result", {16'd0, bus4.result}, {16'd0, exp_res});
            check("hold_cout", {31'd0, bus4.result_cout}, {31'd0, exp_cout});
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check("release_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        check("release_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        check("release_result", {16'd0, bus4.result}, {16'd0, exp_res});
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] full;
        full = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        check("n1_idle_in_ready", {31'd0, bus1.in_ready}, 32'd1);
        bus1.in_valid = 1'b1;
        bus1.op_a     = a;
        bus1.op_b     = b;
        bus1.op_cin   = cin;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check("n1_run_out_valid", {31'd0, bus1.out_valid}, 32'd0);
        check("n1_adder_a", {28'd0, bus1.adder_a}, {28'd0, a});
        @(negedge clk);
        check("n1_out_valid", {31'd0, bus1.out_valid}, 32'd1);
        check("n1_result", {28'd0, bus1.result}, {28'd0, full[3:0]});
        check("n1_cout", {31'd0, bus1.result_cout}, {31'd0, full[4]});
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check("n1_release_in_ready", {31'd0, bus1.in_ready}, 32'd1);
    endtask

    initial begin
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus4.op_a = '0; bus4.op_b = '0; bus4.op_cin = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus1.op_a = '0; bus1.op_b = '0; bus1.op_cin = 1'b0;
`ifdef SERIAL_SUB_EN
        bus4.op_sub = 1'b0;
        bus1.op_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        check("rst_result", {16'd0, bus4.result}, 32'd0);
        check("rst_cout", {31'd0, bus4.result_cout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run4(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        run4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 10);

        // Asynchronous reset during the second RUN cycle
        bus4.in_valid = 1'b1;
        bus4.op_a     = 16'hABCD;
        bus4.op_b     = 16'h1111;
        bus4.op_cin   = 1'b0;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        check("midrst_result", {16'd0, bus4.result}, 32'd0);
        check("midrst_cout", {31'd0, bus4.result_cout}, 32'd0);
        check("midrst_adder_a", {28'd0, bus4.adder_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("postrst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
            check("postrst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        end
        run4(16'h8001, 16'h7FFF, 1'b0, 1'b0, 1);

        for (int i = 0; i < 24; i++) begin
            run4(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
        end

        run1(4'h9, 4'h8, 1'b0);
        run1(4'hF, 4'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run1(4'($urandom), 4'($urandom), 1'($urandom));
        end

`ifdef SERIAL_SUB_EN
        run4(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run4(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
        run4(16'h4321, 16'h4321, 1'b0, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            run4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
